// File: rtl/pio_gen2_pkg.sv
// Shared constants for the second-generation Avalon-MM PIO: register word
// addresses and edge-capture mode encodings.
package pio_gen2_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_INPUT   = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_gen2_edge_cap.sv
// Input synchroniser, edge detector and EDGECAP register for the gen2 PIO.
// PIO_GEN2_IN_SYNC_EN selects a 2-flop synchroniser; otherwise one capture flop.
module pio_gen2_edge_cap
    import pio_gen2_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int EDGE_TYPE = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_i,
    input  logic [WIDTH-1:0] clr_i,
    output logic [WIDTH-1:0] in_sync_o,
    output logic [WIDTH-1:0] edgecap_o
);

`ifdef PIO_GEN2_IN_SYNC_EN
    localparam logic [1:0] PRIME = 2'd3;

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= in_i;
            sync_q <= meta_q;
        end
    end
`else
    localparam logic [1:0] PRIME = 2'd2;

    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= in_i;
        end
    end
`endif

    logic [WIDTH-1:0] prev_q;
    logic [1:0]       prime_q;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic [WIDTH-1:0] raw_edge;
    logic [WIDTH-1:0] edge_w;

    always_comb begin
        case (EDGE_TYPE)
            EDGE_RISE: raw_edge = sync_q & ~prev_q;
            EDGE_FALL: raw_edge = ~sync_q & prev_q;
            default:   raw_edge = sync_q ^ prev_q;
        endcase
        // Until the pipeline holds real samples, its reset zeros would look like edges.
        edge_w    = (prime_q == PRIME) ? raw_edge : '0;
        edgecap_d = (edgecap_q & ~clr_i) | edge_w;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q    <= '0;
            prime_q   <= '0;
            edgecap_q <= '0;
        end else begin
            prev_q    <= sync_q;
            edgecap_q <= edgecap_d;
            if (prime_q != PRIME) begin
                prime_q <= prime_q + 2'd1;
            end
        end
    end

    assign in_sync_o = sync_q;
    assign edgecap_o = edgecap_q;

endmodule

// File: rtl/pio_avalon_gen2.sv
// Gen2 Avalon-MM PIO slave: R/W out register with atomic set/clear, synced
// inputs with edge capture, maskable level irq. Optional macro: PIO_GEN2_IN_SYNC_EN.
module pio_avalon_gen2
    import pio_gen2_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    logic             wr_stb;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] out_q,   out_d;
    logic [WIDTH-1:0] mask_q,  mask_d;
    logic [WIDTH-1:0] clr_d;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] rd_mux;
    logic [31:0]      rdata_q, rdata_d;
    logic             irq_q,   irq_d;
    logic             unused_wdata;

    assign wr_stb       = chipselect && !write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    pio_gen2_edge_cap #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_edge_cap (
        .clk       (clk),
        .reset     (reset),
        .in_i      (in_port),
        .clr_i     (clr_d),
        .in_sync_o (in_sync),
        .edgecap_o (edgecap)
    );

    always_comb begin
        out_d  = out_q;
        mask_d = mask_q;
        clr_d  = '0;
        if (wr_stb) begin
            case (address)
                ADDR_DATA:    out_d  = wdata;
                ADDR_IRQMASK: mask_d = wdata;
                ADDR_EDGECAP: clr_d  = wdata;
                ADDR_OUTSET:  out_d  = out_q | wdata;
                ADDR_OUTCLR:  out_d  = out_q & ~wdata;
                default:      ;
            endcase
        end
    end

    // readdata reloads every cycle so the value is ready one clock after the strobe.
    always_comb begin
        case (address)
            ADDR_DATA:    rd_mux = out_q;
            ADDR_INPUT:   rd_mux = in_sync;
            ADDR_IRQMASK: rd_mux = mask_q;
            ADDR_EDGECAP: rd_mux = edgecap;
            default:      rd_mux = '0;
        endcase
        rdata_d             = '0;
        rdata_d[WIDTH-1:0]  = rd_mux;
        irq_d               = |(edgecap & mask_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= RESET_VALUE;
            mask_q  <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign out_port = out_q;
    assign readdata = rdata_q;
    assign irq      = irq_q;

endmodule
